vga_sync: RTL
=============

Name: vga_sync

Overview:
Timing generator for the 640x480 @ 60 Hz display. It produces the pixel-clock enable, the horizontal and vertical counters, the sync pulses and the visible-area flag. It sits directly upstream of every graphics stage: board, paddle and ball generators consume its x/y. The colour mux gates its output with video_on.

Parameters:
CLK_DIV, 2, system clocks per pixel (50 MHz clk -> 25 MHz pixel); legal range 1..16
H_DISPLAY, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_DISPLAY, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines)
SYNC_ACTIVE, 0, level of hsync/vsync during the pulse (0 = active-low)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
p_tick  output  1  pixel enable, one clk cycle wide, every CLK_DIV clocks
x  output  10  horizontal count, 0..H_TOTAL-1 (H_TOTAL = 800)
y  output  10  vertical count, 0..V_TOTAL-1 (V_TOTAL = 525)
hsync  output  1  horizontal sync to connector
vsync  output  1  vertical sync to connector
video_on  output  1  high when x < H_DISPLAY and y < V_DISPLAY
frame_tick  output  1  one-clk pulse on the last pixel of each frame

Behaviour:
- Single clock domain. Reset is sampled only on the rising edge of clk, synchronous and active-high.
- Reset values:
  - div = 0, x = 0, y = 0.
  - hsync = vsync = !SYNC_ACTIVE.
  - video_on = 1 (consistent with position 0,0).
  - p_tick = 0 when CLK_DIV > 1; p_tick = 1 when CLK_DIV = 1.
  - frame_tick = 0.
- Divider:
  - div counts 0..CLK_DIV-1 and wraps.
  - p_tick = (div == CLK_DIV-1), decoded combinationally from the register.
  - CLK_DIV = 1 means p_tick is constantly 1 outside reset.
- Horizontal counter:
  - x advances only on an edge where p_tick = 1.
  - x wraps from H_TOTAL-1 to 0.
  - H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK.
- Vertical counter:
  - y advances only on an edge where p_tick = 1 and x = H_TOTAL-1.
  - y wraps from V_TOTAL-1 to 0 on that same edge.
  - V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK.
- Register-driven outputs:
  - x and y are driven directly from their registers.
  - hsync, vsync and video_on are registers loaded from the next-state counts, so all three change on the same edge as x/y. There is zero relative latency between position and flags.
- hsync = SYNC_ACTIVE iff H_DISPLAY+H_FRONT <= x <= H_DISPLAY+H_FRONT+H_SYNC-1, i.e. 656..751 by default.
- vsync = SYNC_ACTIVE iff V_DISPLAY+V_FRONT <= y <= V_DISPLAY+V_FRONT+V_SYNC-1, i.e. 490..491 by default.
- video_on boundaries: high at x = 639, low at x = 640. High at y = 479, low at y = 480.
- frame_tick = p_tick & (x == H_TOTAL-1) & (y == V_TOTAL-1), combinational. It is high in exactly one clk cycle per frame.
- Reset asserted mid-frame: on the next edge, all state returns to reset values regardless of p_tick. Counting restarts from (0,0) with div = 0; no partial sync pulse is held.
- x/y are 10 bits wide. H_TOTAL and V_TOTAL must be <= 1024; this is checked by elaboration-time assertion.
- Counters hold their value between p_ticks. Downstream stages sample x/y on any clk; values are stable for CLK_DIV cycles.

Test Plan:
- Reset release, CLK_DIV = 2:
  - p_tick high on cycles 1, 3, 5, ... counting from the first post-reset cycle.
  - x = 1 after 2 clks; x = 799 -> 0 and y = 1 after 1600 clks.
- hsync timing:
  - hsync falls when x becomes 656 (1312 clks after reset) and rises when x becomes 752 (1504 clks).
  - Pulse width is 192 clks; repeats every 1600 clks.
- vsync and frame timing:
  - vsync low exactly while y is 490..491, 3200 clks wide.
  - frame_tick pulses once per 840000 clks, in the cycle before x = y = 0.
- video_on edges:
  - Toggles 1 -> 0 on the same edge x goes 639 -> 640.
  - Stays 0 for all of y = 480..524.
  - Rises again at (0,0).
- Mid-frame reset:
  - Assert reset at x = 700, y = 300 while hsync is low.
  - Next edge gives x = 0, y = 0, hsync = vsync = 1, video_on = 1.
  - Normal timing then resumes.
- CLK_DIV = 1 build:
  - p_tick constantly 1; a line lasts 800 clks and a frame 420000 clks.
  - hsync low for 96 clks.

Source files
------------

// File: rtl/vga_sync.sv
// 640x480 @ 60 Hz raster timing generator: pixel enable, x/y position, syncs,
// visible-area flag and an end-of-frame strobe.
module vga_sync #(
  parameter int unsigned CLK_DIV     = 2,
  parameter int unsigned H_DISPLAY   = 640,
  parameter int unsigned H_FRONT     = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BACK      = 48,
  parameter int unsigned V_DISPLAY   = 480,
  parameter int unsigned V_FRONT     = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BACK      = 33,
  parameter bit          SYNC_ACTIVE = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  output logic       p_tick,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       frame_tick
);

  localparam int unsigned POS_W   = 10;
  localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned HS_LO   = H_DISPLAY + H_FRONT;
  localparam int unsigned HS_HI   = H_DISPLAY + H_FRONT + H_SYNC;
  localparam int unsigned VS_LO   = V_DISPLAY + V_FRONT;
  localparam int unsigned VS_HI   = V_DISPLAY + V_FRONT + V_SYNC;

  // Geometry must fit the 10-bit position counters.
  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_sync: H_TOTAL/V_TOTAL exceed 1024");
  end
  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
    $error("vga_sync: CLK_DIV outside 1..16");
  end

  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] div_next;
  logic [POS_W-1:0] x_next;
  logic [POS_W-1:0] y_next;
  logic             last_x;
  logic             last_y;

  assign last_x     = (x == POS_W'(H_TOTAL - 1));
  assign last_y     = (y == POS_W'(V_TOTAL - 1));
  assign p_tick     = (div == DIV_W'(CLK_DIV - 1));
  assign frame_tick = p_tick & last_x & last_y;

  // Next position: advance one pixel per tick, wrap line then frame.
  always_comb begin
    div_next = p_tick ? '0 : div + DIV_W'(1);
    x_next   = x;
    y_next   = y;
    if (p_tick) begin
      if (last_x) begin
        x_next = '0;
        y_next = last_y ? '0 : y + POS_W'(1);
      end else begin
        x_next = x + POS_W'(1);
      end
    end
  end

  // Flags are loaded from the next position so they line up with x/y.
  always_ff @(posedge clk) begin
    if (reset) begin
      div      <= '0;
      x        <= '0;
      y        <= '0;
      hsync    <= ~SYNC_ACTIVE;
      vsync    <= ~SYNC_ACTIVE;
      video_on <= 1'b1;
    end else begin
      div      <= div_next;
      x        <= x_next;
      y        <= y_next;
      hsync    <= ((32'(x_next) >= HS_LO) && (32'(x_next) < HS_HI)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vsync    <= ((32'(y_next) >= VS_LO) && (32'(y_next) < VS_HI)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      video_on <= (32'(x_next) < H_DISPLAY) && (32'(y_next) < V_DISPLAY);
    end
  end

endmodule
